// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : shared types and sizes for the AES-128 key schedule controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int KS_REG_SIZE   = 32;
  localparam int KS_VEC_SIZE   = 4;
  localparam int AES128_ROUNDS = 10;

  typedef logic [KS_VEC_SIZE-1:0][KS_REG_SIZE-1:0] key_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/key_expansion.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_expansion : one combinational AES-128 key expansion round
// Revision: 1.0
// ---------------------------------------------------------------------------
module key_expansion #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] current_key,
  input  logic [vecSize-1:0][regSize-1:0] round,
  output logic [vecSize-1:0][regSize-1:0] next_key
);

  localparam int NBYTES = regSize / 8;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [regSize-1:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r < regSize'(10)) begin
      rc = 8'h01;
      for (int i = 0; i < 9; i++) begin
        if (regSize'(i) < r) rc = xtime(rc);
      end
    end
    return rc;
  endfunction

  logic [regSize-1:0] round_any;
  logic [regSize-1:0] rot_w;
  logic [regSize-1:0] sub_w;
  logic [regSize-1:0] temp_w;
  logic [regSize-1:0] acc_w;

  // Every lane carries the same broadcast round number
  always_comb begin
    round_any = '0;
    for (int i = 0; i < vecSize; i++) round_any = round_any | round[i];
  end

  assign rot_w = {current_key[vecSize-1][regSize-9:0],
                  current_key[vecSize-1][regSize-1:regSize-8]};

  generate
    for (genvar b = 0; b < NBYTES; b++) begin : g_sbox
      assign sub_w[8*b +: 8] = sbox(rot_w[8*b +: 8]);
    end
  endgenerate

  assign temp_w = sub_w ^ {rcon(round_any), {(regSize-8){1'b0}}};

  always_comb begin
    acc_w    = temp_w;
    next_key = '0;
    for (int w = 0; w < vecSize; w++) begin
      acc_w       = acc_w ^ current_key[w];
      next_key[w] = acc_w;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl : sequences key_expansion over 10 rounds into a key file
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int regSize = KS_REG_SIZE,
  parameter int vecSize = KS_VEC_SIZE,
  parameter int NROUNDS = AES128_ROUNDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  output logic                            busy,
  output logic                            done,
  output logic                            keys_valid,
  input  logic [3:0]                      rd_idx,
  output logic [vecSize-1:0][regSize-1:0] rd_key
);

  logic [vecSize-1:0][regSize-1:0] rf_q [0:NROUNDS];

  ks_state_t  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       kv_q, kv_d;

  logic                            we;
  logic [3:0]                      waddr;
  logic [vecSize-1:0][regSize-1:0] wdata;
  logic [vecSize-1:0][regSize-1:0] cur_key;
  logic [vecSize-1:0][regSize-1:0] next_key;
  logic [vecSize-1:0][regSize-1:0] round_bc;

  assign cur_key = rf_q[rnd_q];

  generate
    for (genvar l = 0; l < vecSize; l++) begin : g_lane
      assign round_bc[l] = {{(regSize-4){1'b0}}, rnd_q};
    end
  endgenerate

  key_expansion #(
    .regSize(regSize),
    .vecSize(vecSize)
  ) u_key_expansion (
    .current_key(cur_key),
    .round      (round_bc),
    .next_key   (next_key)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      rnd_q   <= 4'd0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      kv_q    <= kv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    kv_d    = kv_q;
    we      = 1'b0;
    waddr   = rnd_q + 4'd1;
    wdata   = next_key;
    busy    = (state_q != KS_IDLE);
    done    = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (start) begin
          we      = 1'b1;
          waddr   = 4'd0;
          wdata   = key_in;
          rnd_d   = 4'd0;
          kv_d    = 1'b0;
          state_d = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        we    = 1'b1;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NROUNDS-1)) state_d = KS_DONE;
      end
      KS_DONE: begin
        done    = 1'b1;
        kv_d    = 1'b1;
        state_d = KS_IDLE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  assign keys_valid = kv_q;

  // Key storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (rst_n && we) rf_q[waddr] <= wdata;
  end

  // Registered read with no write bypass: same-edge write returns the old entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_key <= '0;
    end else if (rd_idx <= 4'(NROUNDS)) begin
      rd_key <= rf_q[rd_idx];
    end else begin
      rd_key <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl : randomized self-checking bench with a FIPS-197 model
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  key_t       key_in = '0;
  logic       busy, done, keys_valid;
  logic [3:0] rd_idx = 4'd0;
  key_t       rd_key;

  int checks = 0;
  int errors = 0;
  key_t exp_rk [0:NR];

  localparam key_t FIPS_KEY  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam key_t FIPS_RK1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam key_t FIPS_RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam key_t ZERO_RK1  = {4{32'h62636363}};
  localparam key_t ZERO_RK10 = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .keys_valid(keys_valid),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa  = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] c   = 8'h63;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic build_model(input key_t k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[i];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      for (int j = 0; j < 4; j++) exp_rk[r][j] = w[4*r + j];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic key_t rand_key();
    key_t k;
    for (int j = 0; j < 4; j++) k[j] = $urandom;
    return k;
  endfunction

  // Pulses start with k and returns the number of edges after the start edge until done
  task automatic run_key(input key_t k, output int lat);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    key_in = rand_key();
    lat    = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, keys_valid} !== 3'b000 || rd_key !== '0) begin
      errors++;
      $display("FAIL reset busy/done/kv=%b rd_key=%h exp 000/0", {busy, done, keys_valid}, rd_key);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_key();
    int lat;
    start  = 1'b1;
    key_in = '0;
    tick();
    start  = 1'b0;
    checks++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy busy=%b kv=%b exp 1/0", busy, keys_valid);
    end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL zero_latency got %0d exp 10", lat);
    end
    tick();
    checks++;
    if (done !== 1'b0 || keys_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after_done done=%b kv=%b busy=%b exp 0/1/0", done, keys_valid, busy);
    end
    rd_idx = 4'd1;
    tick();
    checks++;
    if (rd_key !== ZERO_RK1) begin
      errors++;
      $display("FAIL zero_rk1 got %h exp %h", rd_key, ZERO_RK1);
    end
    rd_idx = 4'd10;
    tick();
    checks++;
    if (rd_key !== ZERO_RK10) begin
      errors++;
      $display("FAIL zero_rk10 got %h exp %h", rd_key, ZERO_RK10);
    end
  endtask

  task automatic test_fips();
    int lat;
    build_model(FIPS_KEY);
    run_key(FIPS_KEY, lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL fips_latency got %0d exp 10", lat);
    end
    rd_idx = 4'd1;
    tick();
    checks++;
    if (rd_key !== FIPS_RK1) begin
      errors++;
      $display("FAIL fips_rk1 got %h exp %h", rd_key, FIPS_RK1);
    end
    rd_idx = 4'd10;
    tick();
    checks++;
    if (rd_key !== FIPS_RK10) begin
      errors++;
      $display("FAIL fips_rk10 got %h exp %h", rd_key, FIPS_RK10);
    end
  endtask

  task automatic test_read_port();
    key_t exp;
    logic [3:0] idx;
    for (int i = 0; i < 13; i++) begin
      idx    = (i <= 10) ? 4'(i) : ((i == 11) ? 4'd11 : 4'd15);
      rd_idx = idx;
      tick();
      exp = (idx <= 4'd10) ? exp_rk[idx] : '0;
      checks++;
      if (rd_key !== exp) begin
        errors++;
        $display("FAIL read_idx%0d got %h exp %h", idx, rd_key, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      idx    = 4'($urandom_range(0, 15));
      rd_idx = idx;
      tick();
      exp = (idx <= 4'd10) ? exp_rk[idx] : '0;
      checks++;
      if (rd_key !== exp) begin
        errors++;
        $display("FAIL read_rand_idx%0d got %h exp %h", idx, rd_key, exp);
      end
    end
  endtask

  task automatic test_start_during_expand();
    int first = -1;
    int ndone = 0;
    build_model(FIPS_KEY);
    start  = 1'b1;
    key_in = FIPS_KEY;
    tick();
    start  = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3 || c == 4) begin
        start  = 1'b1;
        key_in = rand_key();
      end else begin
        start  = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (first != 10 || ndone != 1) begin
      errors++;
      $display("FAIL ignore_start first_done=%0d count=%0d exp 10/1", first, ndone);
    end
    for (int i = 0; i <= NR; i++) begin
      rd_idx = 4'(i);
      tick();
      checks++;
      if (rd_key !== exp_rk[i]) begin
        errors++;
        $display("FAIL ignore_start_rk%0d got %h exp %h", i, rd_key, exp_rk[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    start  = 1'b1;
    key_in = rand_key();
    tick();
    start  = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, keys_valid} !== 3'b000 || rd_key !== '0) begin
      errors++;
      $display("FAIL mid_reset busy/done/kv=%b rd_key=%h exp 000/0", {busy, done, keys_valid}, rd_key);
    end
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if ({busy, keys_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_idle busy/kv=%b exp 00", {busy, keys_valid});
    end
    key_in = rand_key();
    build_model(key_in);
    run_key(key_in, lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL mid_reset_restart_latency got %0d exp 10", lat);
    end
    tick();
    for (int i = 0; i <= NR; i++) begin
      rd_idx = 4'(i);
      tick();
      checks++;
      if (rd_key !== exp_rk[i]) begin
        errors++;
        $display("FAIL mid_reset_rk%0d got %h exp %h", i, rd_key, exp_rk[i]);
      end
    end
  endtask

  task automatic test_random_keys();
    int lat;
    int idx;
    key_t k;
    for (int n = 0; n < 3; n++) begin
      k = rand_key();
      build_model(k);
      run_key(k, lat);
      checks++;
      if (lat != 10) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d exp 10", n, lat);
      end
      for (int r = 0; r < 4; r++) begin
        idx    = $urandom_range(0, NR);
        rd_idx = 4'(idx);
        tick();
        checks++;
        if (rd_key !== exp_rk[idx]) begin
          errors++;
          $display("FAIL rand%0d_rk%0d got %h exp %h", n, idx, rd_key, exp_rk[idx]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    key_t k;
    k = rand_key();
    build_model(k);
    start  = 1'b1;
    key_in = k;
    tick();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 11) begin
        checks++;
        if (keys_valid !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle kv=%b busy=%b exp 1/0", keys_valid, busy);
        end
      end
      if (c == 12) begin
        checks++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_retrigger kv=%b busy=%b exp 0/1", keys_valid, busy);
        end
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else begin
          d2    = c;
          start = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (d1 != 10 || d2 - d1 != 12) begin
      errors++;
      $display("FAIL b2b_done_spacing first=%0d second=%0d exp 10/22", d1, d2);
    end
    start = 1'b0;
    tick();
    rd_idx = 4'd10;
    tick();
    checks++;
    if (keys_valid !== 1'b1 || busy !== 1'b0 || rd_key !== exp_rk[10]) begin
      errors++;
      $display("FAIL b2b_final kv=%b busy=%b rk10=%h exp 1/0/%h", keys_valid, busy, rd_key, exp_rk[10]);
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_fips();
    test_read_port();
    test_start_during_expand();
    test_reset_mid();
    test_random_keys();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
